// File: rtl/produto_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package produto_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/produto_seq.sv
// Sequential radix-2 multiplier, unsigned or two's-complement signed,
// producing a 2*WIDTH-bit exact product after a fixed number of cycles.
module produto_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);
  import produto_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               fin;
  logic               mode_r;
  logic               sgn_x;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     mplier;
  logic [WIDTH:0]     abs_a;
  logic [WIDTH:0]     abs_b;

  // Magnitudes carry one extra bit so that -2^(WIDTH-1) negates exactly.
  always_comb begin
    abs_a = {1'b0, a};
    abs_b = {1'b0, b};
    if (mode == MODE_SIGNED && a[WIDTH-1]) abs_a = '0 - {1'b1, a};
    if (mode == MODE_SIGNED && b[WIDTH-1]) abs_b = '0 - {1'b1, b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      fin    <= 1'b0;
      mode_r <= MODE_UNSIGNED;
      sgn_x  <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      p      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_r <= mode;
            sgn_x  <= a[WIDTH-1] ^ b[WIDTH-1];
            mcand  <= {{(WIDTH-1){1'b0}}, abs_a};
            mplier <= abs_b;
            acc    <= '0;
            cnt    <= CW'(WIDTH - 1);
            fin    <= 1'b0;
            state  <= RUN;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          // WIDTH shift-and-add steps, then one cycle to apply the sign and publish p.
          if (!fin) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) fin <= 1'b1;
            else           cnt <= cnt - CW'(1);
          end else begin
            if (mode_r == MODE_SIGNED && sgn_x && acc != '0) p <= '0 - acc;
            else                                             p <= acc;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
